ram_sprite: RTL and testbench



---
 rtl/sprite_pkg.sv | 28 ++
 rtl/sprite_mem_core.sv | 45 ++++
 rtl/ram_sprite.sv | 80 ++++++++
 tb/tb_ram_sprite.sv | 126 ++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants, sprite word layout and FSM state type for the sprite RAM.
package sprite_pkg;

  localparam int RAM_DEPTH = 1024;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 16;

  localparam int X_MSB     = 15;
  localparam int X_LSB     = 10;
  localparam int Y_MSB     = 9;
  localparam int Y_LSB     = 4;
  localparam int COLOR_MSB = 3;
  localparam int COLOR_LSB = 1;
  localparam int STOP_BIT  = 0;

  typedef struct packed {
    logic [5:0] x;
    logic [5:0] y;
    logic [2:0] color;
    logic       stop;
  } sprite_word_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/sprite_mem_core.sv
// Bare 1024x16 array with one write port and a registered, write-through read.
module sprite_mem_core
  import sprite_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [RAM_DEPTH];
  logic [DATA_W-1:0] q_d;
  logic [DATA_W-1:0] q_q;

  // Array has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // New-data read-during-write: a write shows its own data on q.
  always_comb begin
    q_d = mem[addr];
    if (we) begin
      q_d = wdata;
    end else begin
      q_d = mem[addr];
    end
  end

  // Output register, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= {DATA_W{1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/ram_sprite.sv
// Sprite RAM top: post-reset clear sweep, then external read/write access.
module ram_sprite
  import sprite_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // State, clear counter and ready flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= {ADDR_W{1'b0}};
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Next state and port mux; the sweep writes zero, which also keeps q at zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    mem_we    = wren;
    mem_addr  = address;
    mem_wdata = data;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = {DATA_W{1'b0}};
        cnt_d     = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (cnt_q == LAST_ADDR) begin
          state_d = RUN;
          ready_d = 1'b1;
        end else begin
          state_d = CLEAR;
          ready_d = 1'b0;
        end
      end
      RUN: begin
        ready_d = 1'b1;
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = {ADDR_W{1'b0}};
        ready_d = 1'b0;
      end
    endcase
  end

  sprite_mem_core u_core (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .q     (q)
  );

  assign ready = ready_q;

endmodule

// File: tb/tb_ram_sprite.sv
// Directed self-checking bench for ram_sprite.
module tb_ram_sprite;

  logic        clk;
  logic        reset;
  logic [9:0]  address;
  logic [15:0] data;
  logic        wren;
  logic [15:0] q;
  logic        ready;

  int n_cmp;
  int n_fail;

  ram_sprite dut (
    .clk     (clk),
    .reset   (reset),
    .address (address),
    .data    (data),
    .wren    (wren),
    .q       (q),
    .ready   (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rec(input int n);
    logic [5:0] x;
    logic [5:0] y;
    x = 6'(n % 20);
    y = 6'(n / 20);
    return {x, y, 3'b101, 1'b1};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Release reset mid-cycle and check the full 1024-edge sweep.
  task automatic sweep();
    @(posedge clk);
    #2 reset = 1'b0;
    for (int i = 1; i <= 1024; i++) begin
      @(posedge clk);
      #1;
      if (i < 1024) begin
        chk("sweep_ready_low", {15'd0, ready}, 16'd0);
      end else begin
        chk("sweep_ready_high", {15'd0, ready}, 16'd1);
      end
      chk("sweep_q_zero", q, 16'h0000);
    end
  endtask

  task automatic rd(input string tag, input logic [9:0] a, input logic [15:0] exp);
    wren    = 1'b0;
    address = a;
    @(posedge clk);
    #1 chk(tag, q, exp);
  endtask

  task automatic wr(input string tag, input logic [9:0] a, input logic [15:0] d);
    wren    = 1'b1;
    address = a;
    data    = d;
    @(posedge clk);
    #1 chk(tag, q, d);
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    reset   = 1'b1;
    wren    = 1'b0;
    address = 10'd0;
    data    = 16'h0000;
    #1;
    chk("reset_q", q, 16'h0000);
    chk("reset_ready", {15'd0, ready}, 16'd0);

    sweep();
    rd("clear_rd_0", 10'd0, 16'h0000);
    rd("clear_rd_511", 10'd511, 16'h0000);
    rd("clear_rd_1023", 10'd1023, 16'h0000);

    wr("wt_1234", 10'd5, 16'h1234);
    rd("rd_1234", 10'd5, 16'h1234);

    for (int n = 0; n < 800; n++) begin
      wr("seq_wt", 10'(n), rec(n));
    end
    for (int n = 0; n < 800; n++) begin
      rd("seq_rd", 10'(n), rec(n));
    end
    rd("seq_rd_800", 10'd800, 16'h0000);

    wr("wrap_wt_1023", 10'd1023, 16'hAAAA);
    wr("wrap_wt_0", 10'd0, 16'h5555);
    rd("wrap_rd_1023", 10'd1023, 16'hAAAA);
    rd("wrap_rd_0", 10'd0, 16'h5555);

    // Reset in the middle of a cycle while q holds a nonzero word.
    #3 reset = 1'b1;
    #1;
    chk("async_q", q, 16'h0000);
    chk("async_ready", {15'd0, ready}, 16'd0);

    wren    = 1'b1;
    address = 10'd3;
    data    = 16'hFFFF;
    sweep();
    rd("wdc_rd_3", 10'd3, 16'h0000);
    rd("resweep_rd_1023", 10'd1023, 16'h0000);
    rd("resweep_rd_0", 10'd0, 16'h0000);
    rd("resweep_rd_799", 10'd799, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
